alu_iq_shift: RTL

Parametrised, collapsing (shift-compacting) ALU issue queue with IQ_DEPTH entries, kept oldest-at-index-0. It accepts up to DISPATCH_WAYS ops per cycle from dispatch, with per-way acknowledge. It wakes operands from a PRF_BANK_COUNT-bank writeback bus and issues the oldest ready op per cycle to the ALU pipeline under a valid/ready handshake, requesting non-forwarded operands from the PRF. It adds pipeline backpressure, a dispatch acknowledge, same-cycle dispatch wakeup and flush.

---
 rtl/alu_iq_shift_pkg.sv | 34 +++
 rtl/core_types_pkg.sv | 8 +
 rtl/alu_iq_shift_if.sv | 40 ++++
 rtl/pe_lsb.sv | 24 ++
 rtl/alu_iq_shift.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/alu_iq_shift_pkg.sv
// ALU issue queue entry layout and the writeback
// forwarding match helper.
package alu_iq_shift_pkg;
   import core_types_pkg::*;

   localparam int OP_WIDTH = 4;
   localparam int UPPER_W  = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

   typedef logic [LOG_PR_COUNT-1:0]       pr_t;
   typedef logic [LOG_PRF_BANK_COUNT-1:0] bank_t;
   typedef logic [UPPER_W-1:0]            upper_t;

   typedef struct packed {
      logic [OP_WIDTH-1:0] op;
      logic [31:0]         imm;
      pr_t                 A_PR;
      logic                A_unneeded;
      logic                A_ready;
      pr_t                 B_PR;
      logic                is_imm;
      logic                B_ready;
      pr_t                 dest_PR;
   } alu_iq_entry_t;

   function automatic logic pr_fwd(
      input pr_t                          pr,
      input logic [PRF_BANK_COUNT-1:0]    wbv,
      input upper_t [PRF_BANK_COUNT-1:0]  wbu
   );
      bank_t b;
      b = pr[LOG_PRF_BANK_COUNT-1:0];
      return wbv[b] && (wbu[b] == pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]);
   endfunction
endpackage

// File: rtl/core_types_pkg.sv
// Core-wide register file geometry shared by
// rename, issue and writeback logic.
package core_types_pkg;
   localparam int PR_COUNT           = 64;
   localparam int LOG_PR_COUNT       = $clog2(PR_COUNT);
   localparam int PRF_BANK_COUNT     = 4;
   localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
endpackage

// File: rtl/alu_iq_shift_if.sv
// Issue handshake towards the ALU pipeline plus
// the PRF operand read request.
interface alu_iq_shift_if;
   import core_types_pkg::*;
   import alu_iq_shift_pkg::*;

   logic                issue_valid;
   logic                issue_ready;
   logic [OP_WIDTH-1:0] issue_op;
   logic                issue_is_imm;
   logic [31:0]         issue_imm;
   logic                issue_A_unneeded;
   logic                issue_A_forward;
   logic                issue_B_forward;
   bank_t               issue_A_bank;
   bank_t               issue_B_bank;
   pr_t                 issue_dest_PR;
   logic                PRF_req_A_valid;
   logic                PRF_req_B_valid;
   pr_t                 PRF_req_A_PR;
   pr_t                 PRF_req_B_PR;

   modport master (
      output issue_valid, issue_op, issue_is_imm, issue_imm,
      output issue_A_unneeded, issue_A_forward, issue_B_forward,
      output issue_A_bank, issue_B_bank, issue_dest_PR,
      output PRF_req_A_valid, PRF_req_B_valid,
      output PRF_req_A_PR, PRF_req_B_PR,
      input  issue_ready
   );

   modport slave (
      input  issue_valid, issue_op, issue_is_imm, issue_imm,
      input  issue_A_unneeded, issue_A_forward, issue_B_forward,
      input  issue_A_bank, issue_B_bank, issue_dest_PR,
      input  PRF_req_A_valid, PRF_req_B_valid,
      input  PRF_req_A_PR, PRF_req_B_PR,
      output issue_ready
   );
endinterface

// File: rtl/pe_lsb.sv
// Lowest-set-bit priority encoder: one-hot grant,
// binary index and any-set flag.
module pe_lsb #(
   parameter int WIDTH = 8,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] req_i,
   output logic [WIDTH-1:0] onehot_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);
   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      any_o    = |req_i;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            onehot_o    = '0;
            onehot_o[i] = 1'b1;
            idx_o       = IDX_W'(i);
         end
      end
   end
endmodule

// File: rtl/alu_iq_shift.sv
// Collapsing ALU issue queue, oldest entry at index 0,
// oldest-ready select with writeback wakeup.
module alu_iq_shift
   import core_types_pkg::*;
   import alu_iq_shift_pkg::*;
#(
   parameter int IQ_DEPTH      = 8,
   parameter int DISPATCH_WAYS = 4
) (
   input  logic                                   CLK,
   input  logic                                   RST,
   input  logic                                   flush,
   input  logic [DISPATCH_WAYS-1:0]               dispatch_valid_by_way,
   input  logic [DISPATCH_WAYS-1:0][OP_WIDTH-1:0] dispatch_op_by_way,
   input  logic [DISPATCH_WAYS-1:0][31:0]         dispatch_imm_by_way,
   input  pr_t  [DISPATCH_WAYS-1:0]               dispatch_A_PR_by_way,
   input  pr_t  [DISPATCH_WAYS-1:0]               dispatch_B_PR_by_way,
   input  logic [DISPATCH_WAYS-1:0]               dispatch_A_unneeded_by_way,
   input  logic [DISPATCH_WAYS-1:0]               dispatch_is_imm_by_way,
   input  logic [DISPATCH_WAYS-1:0]               dispatch_A_ready_by_way,
   input  logic [DISPATCH_WAYS-1:0]               dispatch_B_ready_by_way,
   input  pr_t  [DISPATCH_WAYS-1:0]               dispatch_dest_PR_by_way,
   output logic [DISPATCH_WAYS-1:0]               dispatch_ack_by_way,
   input  logic [PRF_BANK_COUNT-1:0]              WB_valid_by_bank,
   input  upper_t [PRF_BANK_COUNT-1:0]            WB_upper_PR_by_bank,
   alu_iq_shift_if.master                         iss
);
   localparam int LD = $clog2(IQ_DEPTH);
   localparam int CW = $clog2(IQ_DEPTH + 1);

   alu_iq_entry_t [IQ_DEPTH-1:0]      entry_q, entry_d, entry_upd;
   alu_iq_entry_t [IQ_DEPTH:0]        upd_ext;
   alu_iq_entry_t [DISPATCH_WAYS-1:0] new_e;
   logic [IQ_DEPTH-1:0]               valid_q, valid_d;
   logic [IQ_DEPTH:0]                 valid_ext;
   logic [IQ_DEPTH-1:0]               a_fwd, b_fwd, op_ready;
   logic [IQ_DEPTH-1:0]               sel_oh, free_oh_unused;
   logic [LD-1:0]                     sel_idx, free_idx;
   logic                              sel_any, free_any, fire;
   logic [CW-1:0]                     count, base;
   logic [DISPATCH_WAYS-1:0]          ack;
   int                                free;
   int                                pre_k [DISPATCH_WAYS];
   alu_iq_entry_t                     sel_e;

   // Wakeup is evaluated on the unshifted entries.
   always_comb begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
         a_fwd[i] = pr_fwd(entry_q[i].A_PR, WB_valid_by_bank,
                           WB_upper_PR_by_bank);
         b_fwd[i] = pr_fwd(entry_q[i].B_PR, WB_valid_by_bank,
                           WB_upper_PR_by_bank);
         entry_upd[i]         = entry_q[i];
         entry_upd[i].A_ready = entry_q[i].A_ready | a_fwd[i];
         entry_upd[i].B_ready = entry_q[i].B_ready | b_fwd[i];
         op_ready[i] = valid_q[i]
            & (entry_q[i].A_unneeded | entry_q[i].A_ready | a_fwd[i])
            & (entry_q[i].is_imm | entry_q[i].B_ready | b_fwd[i]);
      end
      upd_ext[IQ_DEPTH-1:0] = entry_upd;
      upd_ext[IQ_DEPTH]     = '0;
      valid_ext             = {1'b0, valid_q};
   end

   always_comb begin
      for (int k = 0; k < DISPATCH_WAYS; k++) begin
         new_e[k].op         = dispatch_op_by_way[k];
         new_e[k].imm        = dispatch_imm_by_way[k];
         new_e[k].A_PR       = dispatch_A_PR_by_way[k];
         new_e[k].A_unneeded = dispatch_A_unneeded_by_way[k];
         new_e[k].A_ready    = dispatch_A_ready_by_way[k]
            | pr_fwd(dispatch_A_PR_by_way[k], WB_valid_by_bank,
                     WB_upper_PR_by_bank);
         new_e[k].B_PR       = dispatch_B_PR_by_way[k];
         new_e[k].is_imm     = dispatch_is_imm_by_way[k];
         new_e[k].B_ready    = dispatch_B_ready_by_way[k]
            | pr_fwd(dispatch_B_PR_by_way[k], WB_valid_by_bank,
                     WB_upper_PR_by_bank);
         new_e[k].dest_PR    = dispatch_dest_PR_by_way[k];
      end
   end

   pe_lsb #(.WIDTH(IQ_DEPTH), .IDX_W(LD)) u_sel (
      .req_i    (op_ready),
      .onehot_o (sel_oh),
      .idx_o    (sel_idx),
      .any_o    (sel_any)
   );

   // Valid bits are contiguous, so the first hole is the occupancy.
   pe_lsb #(.WIDTH(IQ_DEPTH), .IDX_W(LD)) u_free (
      .req_i    (~valid_q),
      .onehot_o (free_oh_unused),
      .idx_o    (free_idx),
      .any_o    (free_any)
   );

   assign count = free_any ? CW'(free_idx) : CW'(IQ_DEPTH);
   assign free  = IQ_DEPTH - int'(count);
   assign sel_e = entry_q[sel_idx];
   assign fire  = iss.issue_valid & iss.issue_ready;
   assign base  = count - CW'(fire);

   assign iss.issue_valid      = sel_any & ~flush;
   assign iss.issue_op         = sel_e.op;
   assign iss.issue_is_imm     = sel_e.is_imm;
   assign iss.issue_imm        = sel_e.imm;
   assign iss.issue_A_unneeded = sel_e.A_unneeded;
   assign iss.issue_A_forward  = a_fwd[sel_idx] & valid_q[sel_idx];
   assign iss.issue_B_forward  = b_fwd[sel_idx] & valid_q[sel_idx];
   assign iss.issue_A_bank     = sel_e.A_PR[LOG_PRF_BANK_COUNT-1:0];
   assign iss.issue_B_bank     = sel_e.B_PR[LOG_PRF_BANK_COUNT-1:0];
   assign iss.issue_dest_PR    = sel_e.dest_PR;

   assign iss.PRF_req_A_valid = fire & ~sel_e.A_unneeded & ~a_fwd[sel_idx];
   assign iss.PRF_req_B_valid = fire & ~sel_e.is_imm & ~b_fwd[sel_idx];
   assign iss.PRF_req_A_PR    = iss.PRF_req_A_valid ? sel_e.A_PR : '0;
   assign iss.PRF_req_B_PR    = iss.PRF_req_B_valid ? sel_e.B_PR : '0;

   always_comb begin
      int pre;
      pre = 0;
      for (int k = 0; k < DISPATCH_WAYS; k++) begin
         pre_k[k] = pre;
         ack[k]   = dispatch_valid_by_way[k] & ~flush & (pre < free);
         pre      = pre + int'(dispatch_valid_by_way[k]);
      end
   end

   assign dispatch_ack_by_way = ack;

   always_comb begin
      logic above;
      above   = 1'b0;
      valid_d = valid_q;
      entry_d = entry_upd;
      for (int i = 0; i < IQ_DEPTH; i++) begin
         above = above | sel_oh[i];
         if (fire && above) begin
            valid_d[i] = valid_ext[i+1];
            entry_d[i] = upd_ext[i+1];
         end
      end
      for (int i = 0; i < IQ_DEPTH; i++) begin
         for (int k = 0; k < DISPATCH_WAYS; k++) begin
            if (ack[k] && (int'(base) + pre_k[k] == i)) begin
               valid_d[i] = 1'b1;
               entry_d[i] = new_e[k];
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q <= '0;
         entry_q <= '0;
      end else if (flush) begin
         valid_q <= '0;
         entry_q <= entry_d;
      end else begin
         valid_q <= valid_d;
         entry_q <= entry_d;
      end
   end
endmodule
